sensor_mean_irq: RTL and testbench

//  Periodic sensor-averaging application core, successor to the single-sensor mean app.
//  A reload timer triggers an external measurement FSM (e.g. the SPI/MAX6682 reader)
//    via a Start/Done handshake. The core averages 2**LOG2_SAMPLES readings.
//  It then raises a one-cycle CPU interrupt on a deviation event (MODE 0) or a limit event (MODE 1).
//  It sits inside the reconfigurable logic; the CPU reads SensorValue_o after the interrupt.

---
 rtl/sensor_mean_irq.sv | 120 ++++++++++++
 tb/tb_sensor_mean_irq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_mean_irq.sv
// Periodic sensor averaging core: a reload timer starts an external measurement, 2**LOG2_SAMPLES
// readings are averaged, and a one-cycle interrupt flags a deviation or upper-limit event.
module sensor_mean_irq #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned LOG2_SAMPLES = 2,
  parameter int unsigned TIMER_WIDTH  = 16
) (
  input  logic                   Clk_i,
  input  logic                   Reset_n_i,
  input  logic                   Enable_i,
  input  logic                   ParamMode_i,
  input  logic [WIDTH-1:0]       ParamThreshold_i,
  input  logic [TIMER_WIDTH-1:0] ParamCounterPreset_i,
  output logic                   MeasStart_o,
  input  logic                   MeasDone_i,
  input  logic [WIDTH-1:0]       MeasValue_i,
  output logic                   CpuIntr_o,
  output logic [WIDTH-1:0]       SensorValue_o
);

  localparam int unsigned AccWidth = WIDTH + LOG2_SAMPLES;
  // One spare bit keeps the counter non-empty when LOG2_SAMPLES is 0.
  localparam int unsigned CntWidth = LOG2_SAMPLES + 1;
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'((1 << LOG2_SAMPLES) - 1);

  localparam logic [1:0] StDisabled = 2'd0;
  localparam logic [1:0] StIdle     = 2'd1;
  localparam logic [1:0] StWait     = 2'd2;
  localparam logic [1:0] StEval     = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic [AccWidth-1:0]    acc_q, acc_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]       value_q, value_d;
  logic                   intr_q, intr_d;

  logic [WIDTH-1:0] mean;
  logic [WIDTH-1:0] deviation;
  logic             event_hit;

  assign mean      = WIDTH'(acc_q >> LOG2_SAMPLES);
  // Unsigned absolute difference; ordering the operands avoids wrap-around.
  assign deviation = (mean >= value_q) ? (mean - value_q) : (value_q - mean);
  assign event_hit = ParamMode_i ? (mean > ParamThreshold_i) : (deviation > ParamThreshold_i);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    intr_d  = 1'b0;
    if (!Enable_i) begin
      state_d = StDisabled;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StDisabled: begin
          state_d = StIdle;
          timer_d = ParamCounterPreset_i;
        end
        StIdle: begin
          if (timer_q != '0) begin
            timer_d = timer_q - TIMER_WIDTH'(1);
          end else begin
            state_d = StWait;
          end
        end
        StWait: begin
          if (MeasDone_i) begin
            acc_d = acc_q + AccWidth'(MeasValue_i);
            cnt_d = cnt_q + CntWidth'(1);
            if (cnt_q == LastCnt) begin
              state_d = StEval;
            end else begin
              state_d = StIdle;
              timer_d = ParamCounterPreset_i;
            end
          end
        end
        StEval: begin
          if (event_hit) begin
            value_d = mean;
            intr_d  = 1'b1;
          end
          acc_d   = '0;
          cnt_d   = '0;
          timer_d = ParamCounterPreset_i;
          state_d = StIdle;
        end
        default: state_d = StDisabled;
      endcase
    end
  end

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state_q <= StDisabled;
      timer_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      intr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      intr_q  <= intr_d;
    end
  end

  assign MeasStart_o   = (state_q == StIdle) && (timer_q == '0);
  assign CpuIntr_o     = intr_q;
  assign SensorValue_o = value_q;

endmodule

// File: tb/tb_sensor_mean_irq.sv
// Self-checking bench for sensor_mean_irq: table vectors, random batches against a mean model,
// and hand sequences for reset, disable/abort and zero-preset back-to-back operation.
module tb_sensor_mean_irq;

  logic        Clk_i = 1'b0;
  logic        Reset_n_i;
  logic        Enable_i;
  logic        ParamMode_i;
  logic [15:0] ParamThreshold_i;
  logic [15:0] ParamCounterPreset_i;
  logic        MeasStart_o;
  logic        MeasDone_i;
  logic [15:0] MeasValue_i;
  logic        CpuIntr_o;
  logic [15:0] SensorValue_o;

  sensor_mean_irq #(
    .WIDTH       (16),
    .LOG2_SAMPLES(2),
    .TIMER_WIDTH (16)
  ) dut (
    .Clk_i               (Clk_i),
    .Reset_n_i           (Reset_n_i),
    .Enable_i            (Enable_i),
    .ParamMode_i         (ParamMode_i),
    .ParamThreshold_i    (ParamThreshold_i),
    .ParamCounterPreset_i(ParamCounterPreset_i),
    .MeasStart_o         (MeasStart_o),
    .MeasDone_i          (MeasDone_i),
    .MeasValue_i         (MeasValue_i),
    .CpuIntr_o           (CpuIntr_o),
    .SensorValue_o       (SensorValue_o)
  );

  always #5 Clk_i = ~Clk_i;

  typedef struct packed {
    logic             mode;
    logic [15:0]      thr;
    logic [3:0][15:0] s;
    logic [3:0]       dly;
    logic             exp_intr;
    logic [15:0]      exp_val;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int since = 0;
  int intr_pulses = 0;
  int exp_pulses = 0;
  int model_sv = 0;

  always @(negedge Clk_i) if (CpuIntr_o === 1'b1) intr_pulses++;

  task automatic cyc();
    @(posedge Clk_i);
    #1;
    since++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic mode, input int thr, input int a, input int b,
                              input int c, input int d, input int dly, input logic ei,
                              input int ev);
    vec_t v;
    v.mode     = mode;
    v.thr      = 16'(thr);
    v.s[0]     = 16'(a);
    v.s[1]     = 16'(b);
    v.s[2]     = 16'(c);
    v.s[3]     = 16'(d);
    v.dly      = 4'(dly);
    v.exp_intr = ei;
    v.exp_val  = 16'(ev);
    return v;
  endfunction

  // Reference: plain integer mean and event rule, tracking the reported value.
  function automatic void ref_eval(input logic mode, input int thr, input int a, input int b,
                                   input int c, input int d, input int prev,
                                   output logic ev, output int val);
    int mean;
    int dev;
    mean = (a + b + c + d) / 4;
    dev  = (mean > prev) ? mean - prev : prev - mean;
    ev   = mode ? (mean > thr) : (dev > thr);
    val  = ev ? mean : prev;
  endfunction

  task automatic wait_start(input string name, input int exp_wait);
    int n;
    n = 0;
    while (MeasStart_o !== 1'b1 && n < 300) begin
      cyc();
      n++;
    end
    if (MeasStart_o !== 1'b1) check({name, "_timeout"}, 32'(MeasStart_o), 1);
    else if (exp_wait >= 0) check(name, since, exp_wait);
  endtask

  // Called with MeasStart_o visible; optionally drives a done in the start cycle (ignored).
  task automatic feed(input logic [15:0] val, input int dly, input bit spur);
    if (spur) begin
      MeasDone_i  = 1'b1;
      MeasValue_i = 16'd7777;
    end
    cyc();
    MeasDone_i  = 1'b0;
    check("start_width", 32'(MeasStart_o), 0);
    repeat (dly - 1) cyc();
    MeasDone_i  = 1'b1;
    MeasValue_i = val;
    cyc();
    MeasDone_i  = 1'b0;
    MeasValue_i = '0;
    since = 0;
  endtask

  task automatic run_batch(input vec_t v, input int first_wait, input bit spur);
    ParamMode_i      = v.mode;
    ParamThreshold_i = v.thr;
    for (int i = 0; i < 4; i++) begin
      wait_start($sformatf("start_gap%0d", i), (i == 0) ? first_wait : int'(ParamCounterPreset_i));
      feed(v.s[i], int'(v.dly), spur && (i == 1));
    end
    check("intr_early", 32'(CpuIntr_o), 0);
    cyc();
    check("intr", 32'(CpuIntr_o), 32'(v.exp_intr));
    check("sensor_value", 32'(SensorValue_o), 32'(v.exp_val));
    if (v.exp_intr) exp_pulses++;
    if (ParamCounterPreset_i != 0) begin
      cyc();
      check("intr_width", 32'(CpuIntr_o), 0);
    end
  endtask

  vec_t vecs [9];

  initial begin
    logic ev;
    int   val;
    int   base;
    int   thr;
    logic m;
    int   a, b, c, d;
    bit   saw;

    vecs[0] = mk(0, 10, 100, 102, 104, 106, 1, 1, 103);
    vecs[1] = mk(0, 10, 104, 105, 106, 105, 3, 0, 103);
    vecs[2] = mk(1, 200, 65535, 65535, 65535, 65535, 2, 1, 65535);
    vecs[3] = mk(1, 200, 150, 150, 150, 150, 1, 0, 65535);
    vecs[4] = mk(0, 0, 3, 4, 5, 6, 2, 1, 4);
    vecs[5] = mk(0, 4, 8, 8, 8, 9, 1, 0, 4);
    vecs[6] = mk(0, 3, 8, 8, 8, 9, 4, 1, 8);
    vecs[7] = mk(1, 8, 8, 8, 8, 8, 1, 0, 8);
    vecs[8] = mk(0, 5, 2, 2, 2, 2, 2, 1, 2);

    // Reset held with Enable high.
    Reset_n_i            = 1'b0;
    Enable_i             = 1'b1;
    ParamMode_i          = 1'b0;
    ParamThreshold_i     = 16'd10;
    ParamCounterPreset_i = 16'd3;
    MeasDone_i           = 1'b0;
    MeasValue_i          = '0;
    saw = 1'b0;
    repeat (5) begin
      cyc();
      if (MeasStart_o) saw = 1'b1;
    end
    check("rst_no_start", 32'(saw), 0);
    check("rst_intr", 32'(CpuIntr_o), 0);
    check("rst_value", 32'(SensorValue_o), 0);
    Reset_n_i = 1'b1;
    since = 0;

    for (int i = 0; i < 9; i++) begin
      run_batch(vecs[i], 4, 1'b0);
      model_sv = int'(vecs[i].exp_val);
    end

    // Random batches around the current reported value.
    for (int k = 0; k < 12; k++) begin
      base = (k % 4 == 0) ? int'($urandom_range(0, 65515)) : ((model_sv > 65500) ? 65480 : model_sv);
      m    = 1'($urandom_range(0, 1));
      thr  = m ? base + int'($urandom_range(0, 20)) : int'($urandom_range(0, 15));
      a    = base + int'($urandom_range(0, 20));
      b    = base + int'($urandom_range(0, 20));
      c    = base + int'($urandom_range(0, 20));
      d    = base + int'($urandom_range(0, 20));
      ref_eval(m, thr, a, b, c, d, model_sv, ev, val);
      run_batch(mk(m, thr, a, b, c, d, int'($urandom_range(1, 4)), ev, val), 4, 1'b0);
      model_sv = val;
    end

    // Abort in sWait after two samples; late and idle dones must be ignored.
    ParamMode_i      = 1'b0;
    ParamThreshold_i = 16'd0;
    wait_start("abort_gap0", 4);
    feed(16'd4000, 1, 1'b0);
    wait_start("abort_gap1", 3);
    feed(16'd4000, 2, 1'b0);
    wait_start("abort_gap2", 3);
    cyc();
    Enable_i = 1'b0;
    cyc();
    check("dis_start", 32'(MeasStart_o), 0);
    MeasDone_i  = 1'b1;
    MeasValue_i = 16'd60000;
    cyc();
    MeasDone_i  = 1'b0;
    repeat (3) cyc();
    check("dis_hold", 32'(SensorValue_o), 32'(model_sv));
    check("dis_intr", 32'(CpuIntr_o), 0);
    Enable_i = 1'b1;
    since = 0;
    cyc();
    MeasDone_i  = 1'b1;
    MeasValue_i = 16'd9999;
    cyc();
    MeasDone_i  = 1'b0;
    ref_eval(1'b0, 0, 8, 8, 8, 8, model_sv, ev, val);
    run_batch(mk(0, 0, 8, 8, 8, 8, 1, ev, val), 4, 1'b0);
    model_sv = val;

    // Zero preset: back-to-back starts, spurious done in a start cycle.
    Enable_i = 1'b0;
    cyc();
    ParamCounterPreset_i = 16'd0;
    Enable_i = 1'b1;
    since = 0;
    ref_eval(1'b1, 0, 5, 5, 5, 5, model_sv, ev, val);
    run_batch(mk(1, 0, 5, 5, 5, 5, 1, ev, val), 1, 1'b1);
    model_sv = val;
    ref_eval(1'b1, 65535, 9, 9, 9, 9, model_sv, ev, val);
    run_batch(mk(1, 65535, 9, 9, 9, 9, 1, ev, val), 1, 1'b0);
    model_sv = val;
    repeat (3) cyc();
    check("intr_pulse_total", intr_pulses, exp_pulses);

    // Asynchronous reset mid-operation.
    @(posedge Clk_i);
    #3;
    Reset_n_i = 1'b0;
    #1;
    check("async_value", 32'(SensorValue_o), 0);
    check("async_start", 32'(MeasStart_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
